// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the multiplexed 4-digit 7-segment display scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low (common-anode display).
package bcd_disp_pkg;

  typedef logic [1:0] dig_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern.
// Non-decimal nibbles (A-F) are shown as a dash.
module bcd_seg_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (nibble)
      4'd0: seg_n = SEG_DIGIT[0];
      4'd1: seg_n = SEG_DIGIT[1];
      4'd2: seg_n = SEG_DIGIT[2];
      4'd3: seg_n = SEG_DIGIT[3];
      4'd4: seg_n = SEG_DIGIT[4];
      4'd5: seg_n = SEG_DIGIT[5];
      4'd6: seg_n = SEG_DIGIT[6];
      4'd7: seg_n = SEG_DIGIT[7];
      4'd8: seg_n = SEG_DIGIT[8];
      4'd9: seg_n = SEG_DIGIT[9];
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed 4-digit scanner with tear-free frame-boundary commit and leading-zero blanking.
// Define DISP_BLANK_GAP_EN to turn all anodes off for GAP_CYCLES at the start of each slot.
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int PRESCALE   = 50000,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        frame_done
);

  localparam int PW = $clog2(PRESCALE);
`ifdef DISP_BLANK_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic [PW-1:0] presc;
  dig_idx_t      dig_idx;
  logic [15:0]   disp;
  logic [15:0]   pend;
  logic          pend_full;

  logic          tick;
  logic          wrap;
  logic          accept;
  logic          gap;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_dec;

  assign tick     = (presc == PW'(PRESCALE - 1));
  assign wrap     = tick && (dig_idx == 2'd3);
  assign in_ready = ~pend_full;
  assign accept   = in_valid && ~pend_full;
  assign gap      = GAP_EN && (presc < PW'(GAP_CYCLES));

  // A digit is blanked when it and every more-significant digit are zero.
  always_comb begin
    nib   = disp[3:0];
    blank = 1'b0;
    case (dig_idx)
      2'd0: begin
        nib   = disp[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        nib   = disp[7:4];
        blank = (disp[15:4] == 12'h000);
      end
      2'd2: begin
        nib   = disp[11:8];
        blank = (disp[15:8] == 8'h00);
      end
      default: begin
        nib   = disp[15:12];
        blank = (disp[15:12] == 4'h0);
      end
    endcase
  end

  bcd_seg_decode u_dec (
    .nibble (nib),
    .seg_n  (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      dig_idx    <= '0;
      disp       <= 16'h0000;
      pend       <= 16'h0000;
      pend_full  <= 1'b0;
      seg_n      <= SEG_BLANK;
      an_n       <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;

      if (tick) begin
        presc   <= '0;
        dig_idx <= dig_idx + 2'd1;
      end else begin
        presc <= presc + PW'(1);
      end

      // Accept needs an empty pend and commit needs a full one, so they never coincide.
      if (accept) begin
        pend      <= bcd_in;
        pend_full <= 1'b1;
      end else if (wrap && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end

      seg_n <= blank ? SEG_BLANK : seg_dec;
      an_n  <= gap ? 4'hF : ~(4'b0001 << dig_idx);
    end
  end

endmodule
